image_pad_scheduler: RTL and testbench

Layer-level controller for the image padding stage. It accepts a per-layer padding command, validates it, drives the padding engine's static configuration and `Start` input, and reissues `Start` once per input feature plane. It tracks completion by counting the engine's output write strobes, then reports layer done. It sits between the layer-configuration register file and the padding engine; it is the only source of the engine's configuration and start.

---
 rtl/image_pad_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_image_pad_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_pad_scheduler.sv
// Layer-level scheduler for the padding engine: validates a layer command, holds the
// engine's static configuration, restarts the engine once per plane and counts its output beats.
module image_pad_scheduler #(
  parameter int PLANE_BITS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Cmd_Valid,
  output logic                  Cmd_Ready,
  input  logic                  Cmd_Padding,
  input  logic [2:0]            Cmd_Zero_Num,
  input  logic [10:0]           Cmd_Row_Num,
  input  logic [PLANE_BITS-1:0] Cmd_Plane_Num,
  input  logic                  Abort,
  input  logic                  Pad_Write_EN,
  output logic                  Padding_REG,
  output logic [2:0]            Zero_Num_REG,
  output logic [10:0]           Row_Num_In_REG,
  output logic                  Pad_Start,
  output logic                  Pad_Rst,
  output logic                  Busy,
  output logic [PLANE_BITS-1:0] Plane_Cnt,
  output logic                  Layer_Done,
  output logic                  Cmd_Err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    START  = 3'd2,
    RUN    = 3'd3,
    GAP    = 3'd4,
    DONE   = 3'd5,
    ABORT  = 3'd6
  } state_t;

  localparam logic [11:0]           OUT_LIMIT = 12'd1023;
  localparam logic [PLANE_BITS-1:0] PLANE_ONE = 1;
  localparam logic [PLANE_BITS:0]   PLANE_ONE_EXT = 1;

  state_t                state_q, state_d;
  logic                  phase_q, phase_d;
  logic [23:0]           beat_cnt_q, beat_cnt_d;
  logic [23:0]           beats_q;
  logic [PLANE_BITS-1:0] plane_num_q;
  logic [PLANE_BITS-1:0] plane_cnt_q, plane_cnt_d;
  logic                  pad_q, pad_d;
  logic [2:0]            zero_q, zero_d;
  logic [10:0]           row_q, row_d;
  logic                  start_q, start_d;
  logic                  prst_q, prst_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [11:0] out_w;
  logic [23:0] beats_w;
  logic        accept;
  logic        cmd_bad;
  logic        beat_hit;
  logic        beat_last;
  logic        more_planes;

  function automatic logic [11:0] out_size(input logic       pad,
                                           input logic [2:0]  zero,
                                           input logic [10:0] row);
    out_size = {1'b0, row} + (pad ? {8'd0, zero, 1'b0} : 12'd0);
  endfunction

  assign out_w       = out_size(Cmd_Padding, Cmd_Zero_Num, Cmd_Row_Num);
  assign beats_w     = {12'd0, out_w} * {12'd0, out_w};
  assign cmd_bad     = (Cmd_Row_Num == 11'd0) || (Cmd_Plane_Num == '0) || (out_w > OUT_LIMIT);
  assign accept      = Cmd_Valid && (state_q == IDLE);
  assign beat_hit    = Pad_Write_EN && (state_q == RUN);
  assign beat_last   = beat_hit && ((beat_cnt_q + 24'd1) == beats_q);
  assign more_planes = ({1'b0, plane_cnt_q} + PLANE_ONE_EXT) < {1'b0, plane_num_q};

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    beat_cnt_d  = beat_cnt_q;
    plane_cnt_d = plane_cnt_q;
    pad_d       = pad_q;
    zero_d      = zero_q;
    row_d       = row_q;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          plane_cnt_d = '0;
          if (cmd_bad) begin
            err_d = 1'b1;
          end else begin
            state_d = SETTLE;
            phase_d = 1'b0;
            pad_d   = Cmd_Padding;
            zero_d  = Cmd_Zero_Num;
            row_d   = Cmd_Row_Num;
          end
        end
      end
      SETTLE, GAP: begin
        if (phase_q) state_d = START;
        else         phase_d = 1'b1;
      end
      START: begin
        beat_cnt_d = '0;
        state_d    = RUN;
      end
      RUN: begin
        if (beat_hit) beat_cnt_d = beat_cnt_q + 24'd1;
        if (beat_last) begin
          if (more_planes) begin
            state_d     = GAP;
            phase_d     = 1'b0;
            plane_cnt_d = plane_cnt_q + PLANE_ONE;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:  state_d = IDLE;
      ABORT: begin
        if (phase_q) state_d = IDLE;
        else         phase_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Abort outranks everything, including a final beat landing on the same edge.
    if (Abort && (state_q != IDLE)) begin
      state_d     = ABORT;
      phase_d     = 1'b0;
      plane_cnt_d = plane_cnt_q;
    end

    start_d = (state_d == START);
    prst_d  = (state_d == ABORT);
    done_d  = (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_q     <= 1'b0;
      beat_cnt_q  <= '0;
      plane_cnt_q <= '0;
      pad_q       <= 1'b0;
      zero_q      <= '0;
      row_q       <= '0;
      start_q     <= 1'b0;
      prst_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      beat_cnt_q  <= beat_cnt_d;
      plane_cnt_q <= plane_cnt_d;
      pad_q       <= pad_d;
      zero_q      <= zero_d;
      row_q       <= row_d;
      start_q     <= start_d;
      prst_q      <= prst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Layer size limits are only consulted while not IDLE, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept && !cmd_bad) begin
      beats_q     <= beats_w;
      plane_num_q <= Cmd_Plane_Num;
    end
  end

  assign Cmd_Ready      = (state_q == IDLE);
  assign Padding_REG    = pad_q;
  assign Zero_Num_REG   = zero_q;
  assign Row_Num_In_REG = row_q;
  assign Pad_Start      = start_q;
  assign Pad_Rst        = prst_q;
  assign Busy           = busy_q;
  assign Plane_Cnt      = plane_cnt_q;
  assign Layer_Done     = done_q;
  assign Cmd_Err        = err_q;

endmodule

// File: tb/tb_image_pad_scheduler.sv
// Bench for image_pad_scheduler: builds a per-cycle timeline of stimulus and expected outputs
// from layer-level rules, then replays the stimulus and compares every cycle.
module tb_image_pad_scheduler;
  localparam int PB = 10;
  localparam int N  = 16384;

  logic          clk = 1'b0;
  logic          rst;
  logic          Cmd_Valid, Cmd_Ready, Cmd_Padding, Abort, Pad_Write_EN;
  logic [2:0]    Cmd_Zero_Num, Zero_Num_REG;
  logic [10:0]   Cmd_Row_Num, Row_Num_In_REG;
  logic [PB-1:0] Cmd_Plane_Num, Plane_Cnt;
  logic          Padding_REG, Pad_Start, Pad_Rst, Busy, Layer_Done, Cmd_Err;

  always #5 clk = ~clk;

  image_pad_scheduler #(.PLANE_BITS(PB)) dut (
    .clk(clk), .rst(rst), .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready),
    .Cmd_Padding(Cmd_Padding), .Cmd_Zero_Num(Cmd_Zero_Num), .Cmd_Row_Num(Cmd_Row_Num),
    .Cmd_Plane_Num(Cmd_Plane_Num), .Abort(Abort), .Pad_Write_EN(Pad_Write_EN),
    .Padding_REG(Padding_REG), .Zero_Num_REG(Zero_Num_REG), .Row_Num_In_REG(Row_Num_In_REG),
    .Pad_Start(Pad_Start), .Pad_Rst(Pad_Rst), .Busy(Busy), .Plane_Cnt(Plane_Cnt),
    .Layer_Done(Layer_Done), .Cmd_Err(Cmd_Err)
  );

  // Stimulus index e: value seen by the DUT at clock edge e.
  bit            i_rst[N], i_val[N], i_pad[N], i_abort[N], i_en[N];
  logic [2:0]    i_zero[N];
  logic [10:0]   i_row[N];
  logic [PB-1:0] i_planes[N];
  // Expected index s: outputs observed at the falling edge after clock edge s.
  bit            x_ready[N], x_busy[N], x_start[N], x_prst[N], x_done[N], x_err[N], x_pad[N];
  logic [2:0]    x_zero[N];
  logic [10:0]   x_row[N];
  int            x_pc[N];
  // Observed pulses, kept for the per-scenario literal checks.
  bit            d_start[N], d_done[N], d_prst[N], d_err[N], d_busy[N];
  int            d_pc[N], d_row[N];

  int         cur_pc;
  bit         cur_pad;
  logic [2:0] cur_zero;
  logic [10:0] cur_row;
  int         L;
  int         last_s;
  int         checks, errors;

  function automatic int out_of(bit pad, int zero, int row);
    return row + (pad ? 2 * zero : 0);
  endfunction

  function automatic int beats_of(bit pad, int zero, int row);
    int o;
    o = out_of(pad, zero, row);
    return o * o;
  endfunction

  function automatic bit rejects(bit pad, int zero, int row, int planes);
    return (row == 0) || (planes == 0) || (out_of(pad, zero, row) > 1023);
  endfunction

  task automatic chk(input string name, input int s, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @%0d: got %0d expected %0d", name, s, act, exp);
    end
  endtask

  task automatic put(input int s, input bit busy, input bit start, input bit prst,
                     input bit done, input bit err);
    if (s >= N - 2) begin
      $display("FAIL plan_overflow @%0d: got %0d expected <%0d", s, s, N - 2);
      $fatal(1, "timeline exceeds bench arrays");
    end
    x_ready[s] = !busy;
    x_busy[s]  = busy;
    x_start[s] = start;
    x_prst[s]  = prst;
    x_done[s]  = done;
    x_err[s]   = err;
    x_pc[s]    = cur_pc;
    x_pad[s]   = cur_pad;
    x_zero[s]  = cur_zero;
    x_row[s]   = cur_row;
  endtask

  // A busy cycle; commands offered now must be ignored.
  task automatic run_put(input int s);
    put(s, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    if ($urandom_range(0, 7) == 0) i_val[s + 1] = 1'b1;
  endtask

  task automatic do_abort(input int a, output int last);
    i_abort[a] = 1'b1;
    put(a,     1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    put(a + 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    put(a + 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    last = a + 2;
  endtask

  task automatic do_reset(input int x, output int last);
    cur_pc = 0; cur_pad = 1'b0; cur_zero = '0; cur_row = '0;
    for (int k = 1; k <= 3; k++) i_rst[x + k] = 1'b1;
    for (int k = 0; k <= 3; k++) put(x + k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    last = x + 3;
  endtask

  // Timeline of one command accepted at edge t; returns the last sample it defines (idle).
  task automatic plan_layer(input int t, input bit pad, input int zero, input int row,
                            input int planes, input int abort_n, input bit abort_start,
                            input int rst_n, output int last);
    int beats, s0, e, cnt, g;
    i_val[t] = 1'b1; i_pad[t] = pad; i_zero[t] = 3'(zero);
    i_row[t] = 11'(row); i_planes[t] = PB'(planes);
    cur_pc = 0;
    if (rejects(pad, zero, row, planes)) begin
      put(t, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      last = t;
      return;
    end
    cur_pad = pad; cur_zero = 3'(zero); cur_row = 11'(row);
    beats = beats_of(pad, zero, row);
    put(t,     1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    put(t + 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    s0 = t + 2;
    g = 0;
    for (int p = 0; p < planes; p++) begin
      put(s0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      if (abort_start) begin
        do_abort(s0 + 1, last);
        return;
      end
      run_put(s0 + 1);
      e = s0 + 2;
      cnt = 0;
      while (1) begin
        if (i_en[e]) begin
          cnt++; g++;
          if (g == abort_n) begin do_abort(e, last); return; end
          if (g == rst_n)   begin do_reset(e, last); return; end
          if (cnt == beats) break;
        end
        run_put(e);
        e++;
      end
      if (p == planes - 1) begin
        put(e,     1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        put(e + 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        last = e + 1;
        return;
      end
      cur_pc++;
      put(e,     1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      put(e + 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      s0 = e + 2;
    end
    last = s0;
  endtask

  task automatic layer(input int gap, input bit pad, input int zero, input int row,
                       input int planes, input int abort_n, input bit abort_start,
                       input int rst_n, output int t_acc);
    int t;
    t = L + gap;
    for (int s = L + 1; s < t; s++) begin
      put(s, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if ($urandom_range(0, 3) == 0) i_abort[s] = 1'b1;
    end
    plan_layer(t, pad, zero, row, planes, abort_n, abort_start, rst_n, L);
    t_acc = t;
  endtask

  task automatic apply(input int e);
    rst           = i_rst[e];
    Cmd_Valid     = i_val[e];
    Cmd_Padding   = i_pad[e];
    Cmd_Zero_Num  = i_zero[e];
    Cmd_Row_Num   = i_row[e];
    Cmd_Plane_Num = i_planes[e];
    Abort         = i_abort[e];
    Pad_Write_EN  = i_en[e];
  endtask

  task automatic check_sample(input int s);
    chk("Cmd_Ready",      s, Cmd_Ready,      x_ready[s]);
    chk("Busy",           s, Busy,           x_busy[s]);
    chk("Pad_Start",      s, Pad_Start,      x_start[s]);
    chk("Pad_Rst",        s, Pad_Rst,        x_prst[s]);
    chk("Layer_Done",     s, Layer_Done,     x_done[s]);
    chk("Cmd_Err",        s, Cmd_Err,        x_err[s]);
    chk("Plane_Cnt",      s, Plane_Cnt,      x_pc[s]);
    chk("Padding_REG",    s, Padding_REG,    x_pad[s]);
    chk("Zero_Num_REG",   s, Zero_Num_REG,   x_zero[s]);
    chk("Row_Num_In_REG", s, Row_Num_In_REG, x_row[s]);
    d_start[s] = Pad_Start; d_done[s] = Layer_Done; d_prst[s] = Pad_Rst;
    d_err[s] = Cmd_Err; d_busy[s] = Busy; d_pc[s] = Plane_Cnt; d_row[s] = Row_Num_In_REG;
  endtask

  int t_single, l_single, t_multi, l_multi, t_rej0, t_big, t_abort, l_abort, t_absame, l_absame;
  int t_unused, n_start, n_done, n_prst, k;

  initial begin
    checks = 0; errors = 0;
    for (int e = 0; e < N; e++) begin
      i_en[e]     = ($urandom_range(0, 9) < 6);
      i_pad[e]    = 1'($urandom_range(0, 1));
      i_zero[e]   = 3'($urandom_range(0, 7));
      i_row[e]    = 11'($urandom_range(0, 2047));
      i_planes[e] = PB'($urandom_range(0, 7));
    end
    cur_pc = 0; cur_pad = 1'b0; cur_zero = '0; cur_row = '0;
    for (int s = 0; s <= 2; s++) begin
      i_rst[s] = 1'b1;
      put(s, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    L = 2;

    layer(3, 1'b1, 1, 4,    1, -1, 1'b0, -1, t_single); l_single = L;
    layer(2, 1'b0, 0, 3,    3, -1, 1'b0, -1, t_multi);  l_multi  = L;
    layer(2, 1'b1, 1, 0,    1, -1, 1'b0, -1, t_rej0);
    layer(2, 1'b1, 2, 1020, 1, -1, 1'b0, -1, t_unused);
    layer(2, 1'b1, 2, 1019, 2,  5, 1'b0, -1, t_big);
    layer(2, 1'b0, 0, 5,    0, -1, 1'b0, -1, t_unused);
    layer(3, 1'b1, 1, 4,    1, 11, 1'b0, -1, t_abort);  l_abort  = L;
    layer(1, 1'b0, 0, 2,    2, -1, 1'b0, -1, t_unused);
    layer(2, 1'b0, 0, 2,    1,  4, 1'b0, -1, t_absame); l_absame = L;
    layer(2, 1'b0, 0, 2,    2, -1, 1'b1, -1, t_unused);
    layer(2, 1'b0, 0, 3,    3, -1, 1'b0, 13, t_unused);
    for (int r = 0; r < 8; r++) begin
      layer($urandom_range(1, 4), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
            ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5),
            ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3),
            -1, 1'b0, -1, t_unused);
    end
    last_s = L + 6;
    for (int s = L + 1; s < last_s; s++) put(s, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Hand-derived anchors for the model itself.
    chk("model_beats_single", 0, beats_of(1'b1, 1, 4), 36);
    chk("model_beats_multi",  0, beats_of(1'b0, 0, 3), 9);
    chk("model_out_1024",     0, out_of(1'b1, 2, 1020), 1024);
    chk("model_rej_1024",     0, rejects(1'b1, 2, 1020, 1), 1);
    chk("model_acc_1023",     0, rejects(1'b1, 2, 1019, 1), 0);
    chk("model_start_T+3",    t_single, x_start[t_single + 2], 1);

    fork
      begin
        apply(0);
        for (int e = 0; e < last_s; e++) begin
          @(posedge clk);
          #1;
          apply(e + 1);
        end
      end
      begin
        @(posedge clk);
        for (int s = 0; s < last_s; s++) begin
          @(negedge clk);
          check_sample(s);
        end
      end
    join

    // Scenario-level literal expectations on what the DUT produced.
    chk("single_start_at_T+3", t_single, d_start[t_single + 2], 1);
    n_start = 0; n_done = 0;
    for (int s = t_single; s <= l_single; s++) begin
      n_start += int'(d_start[s]); n_done += int'(d_done[s]);
    end
    chk("single_start_count", t_single, n_start, 1);
    chk("single_done_count",  t_single, n_done, 1);
    chk("single_busy_low_after_done", l_single, d_busy[l_single], 0);

    n_start = 0; n_done = 0; k = 0;
    for (int s = t_multi; s <= l_multi; s++) begin
      if (d_start[s]) begin
        chk("multi_plane_cnt_at_start", s, d_pc[s], k);
        k++;
      end
      n_start += int'(d_start[s]); n_done += int'(d_done[s]);
    end
    chk("multi_start_count", t_multi, n_start, 3);
    chk("multi_done_count",  t_multi, n_done, 1);

    chk("rej_row0_err",  t_rej0, d_err[t_rej0], 1);
    chk("rej_row0_busy", t_rej0, d_busy[t_rej0], 0);
    chk("acc_1023_row_reg", t_big, d_row[t_big], 1019);

    n_prst = 0; n_done = 0;
    for (int s = t_abort; s <= l_abort; s++) begin
      n_prst += int'(d_prst[s]); n_done += int'(d_done[s]);
    end
    chk("abort_prst_cycles", t_abort, n_prst, 2);
    chk("abort_no_done",     t_abort, n_done, 0);

    n_done = 0;
    for (int s = t_absame; s <= l_absame; s++) n_done += int'(d_done[s]);
    chk("abort_final_beat_no_done", t_absame, n_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
